cpu_step_ctrl: RTL and testbench

Clock-enable controller for the 32-bit core, directly downstream of the slow-clock frequency divider. It samples the divider's slow clock in the fast `clk_i` domain and detects its rising edges. It combines those edges with a run/step switch, a debounced single-step pushbutton and the core's halt flag. The output is a one-cycle `cpu_en_o` pulse that advances the processor. All core logic stays on `clk_i`; the divided signal is never used as a clock.

---
 rtl/cpu_step_ctrl_if.sv | 23 ++
 rtl/cpu_step_ctrl.sv | 135 +++++++++++++
 tb/tb_cpu_step_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_step_ctrl_if.sv
// Signal bundle between the step controller and its environment.
// The master side drives the switch, button, divider and halt inputs; the slave side is the controller.
interface cpu_step_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             slow_clk_i;
    logic             run_i;
    logic             step_ni;
    logic             halt_i;
    logic             cpu_en_o;
    logic [CNT_W-1:0] step_cnt_o;
    logic [1:0]       state_o;

    modport master (
        output slow_clk_i, run_i, step_ni, halt_i,
        input  cpu_en_o, step_cnt_o, state_o
    );

    modport slave (
        input  slow_clk_i, run_i, step_ni, halt_i,
        output cpu_en_o, step_cnt_o, state_o
    );
endinterface

// File: rtl/cpu_step_ctrl.sv
// Turns slow-clock rising edges, the run/step switch and a debounced step button
// into single-cycle clock-enable pulses for the core, all within the clk_i domain.
module cpu_step_ctrl #(
    parameter int DEB_CYCLES = 1000000,
    parameter int DEB_W      = 20,
    parameter int CNT_W      = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    cpu_step_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_STOP = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES - 1);

    logic [2:0]       slow_sync_r;
    logic [1:0]       run_sync_r;
    logic [1:0]       step_sync_r;
    logic [DEB_W-1:0] deb_cnt_r;
    logic             deb_r;
    logic             deb_d_r;
    state_t           state_r;
    logic             cpu_en_r;
    logic [CNT_W-1:0] step_cnt_r;

    logic tick_s;
    logic run_s;
    logic pressed_s;
    logic press_s;

    assign tick_s    = slow_sync_r[1] & ~slow_sync_r[2];
    assign run_s     = run_sync_r[1];
    assign pressed_s = ~step_sync_r[1];
    assign press_s   = deb_r & ~deb_d_r;

    // Synchronisers; slow chain resets high so a high divider at reset release gives no tick.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slow_sync_r <= 3'b111;
            run_sync_r  <= 2'b00;
            step_sync_r <= 2'b11;
        end else begin
            slow_sync_r <= {slow_sync_r[1:0], bus.slow_clk_i};
            run_sync_r  <= {run_sync_r[0], bus.run_i};
            step_sync_r <= {step_sync_r[0], bus.step_ni};
        end
    end

    // Debouncer: accept a new button level only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            deb_cnt_r <= '0;
            deb_r     <= 1'b0;
            deb_d_r   <= 1'b0;
        end else begin
            deb_d_r <= deb_r;
            if (pressed_s == deb_r) begin
                deb_cnt_r <= '0;
            end else if (deb_cnt_r == DEB_MAX) begin
                deb_r     <= pressed_s;
                deb_cnt_r <= '0;
            end else begin
                deb_cnt_r <= deb_cnt_r + {{(DEB_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Mode FSM with registered pulse and step counter; halt beats mode change beats press/tick.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_STOP;
            cpu_en_r   <= 1'b0;
            step_cnt_r <= '0;
        end else begin
            cpu_en_r <= 1'b0;
            case (state_r)
                ST_STOP: begin
                    if (bus.halt_i) begin
                        state_r <= ST_HALT;
                    end else if (run_s) begin
                        state_r <= ST_RUN;
                    end else if (press_s) begin
                        state_r <= ST_STEP;
                    end else begin
                        state_r <= ST_STOP;
                    end
                end
                ST_RUN: begin
                    if (bus.halt_i) begin
                        state_r <= ST_HALT;
                    end else if (!run_s) begin
                        state_r <= ST_STOP;
                    end else if (tick_s) begin
                        cpu_en_r   <= 1'b1;
                        step_cnt_r <= step_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_STEP: begin
                    if (bus.halt_i) begin
                        state_r <= ST_HALT;
                    end else if (run_s) begin
                        state_r <= ST_RUN;
                    end else if (tick_s) begin
                        cpu_en_r   <= 1'b1;
                        step_cnt_r <= step_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_r    <= ST_STOP;
                    end else begin
                        state_r <= ST_STEP;
                    end
                end
                ST_HALT: begin
                    if (!bus.halt_i) begin
                        state_r <= ST_STOP;
                    end else begin
                        state_r <= ST_HALT;
                    end
                end
                default: begin
                    state_r <= ST_STOP;
                end
            endcase
        end
    end

    assign bus.cpu_en_o   = cpu_en_r;
    assign bus.step_cnt_o = step_cnt_r;
    assign bus.state_o    = state_r;
endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl with DEB_CYCLES=4 and a 4-bit step counter.
module tb_cpu_step_ctrl;
    localparam int CNT_W = 4;

    typedef struct {
        logic [CNT_W-1:0] cnt;
        int               cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   total;
    int   bad;
    int   press_cnt;
    logic [CNT_W-1:0] exp_cnt;
    exp_t exp_q[$];

    cpu_step_ctrl_if #(.CNT_W(CNT_W)) bus ();

    cpu_step_ctrl #(
        .DEB_CYCLES(4),
        .DEB_W     (3),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pulse monitor: every pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && bus.cpu_en_o) begin
            if (exp_q.size() == 0) begin
                check("spurious_pulse", {31'd0, bus.cpu_en_o}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_cnt", {28'd0, bus.step_cnt_o}, {28'd0, e.cnt});
            end
        end
        if (rst_n && dut.press_s) press_cnt++;
    end

    task automatic slow_edge(input bit exp_pulse);
        bus.slow_clk_i = 1'b1;
        if (exp_pulse) begin
            exp_cnt = exp_cnt + 4'd1;
            exp_q.push_back('{cnt: exp_cnt, cyc: cyc + 3});
        end
        repeat (5) @(negedge clk);
        bus.slow_clk_i = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        exp_cnt = 4'd0;
        rst_n = 1'b1;
    endtask

    initial begin
        cyc            = 0;
        total          = 0;
        bad            = 0;
        press_cnt      = 0;
        exp_cnt        = 4'd0;
        rst_n          = 1'b0;
        bus.slow_clk_i = 1'b1;
        bus.run_i      = 1'b0;
        bus.step_ni    = 1'b1;
        bus.halt_i     = 1'b0;

        // Reset with the divider held high: no tick, stay in STOP.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("reset_state", {30'd0, bus.state_o}, 32'd0);
        end
        check("reset_cnt", {28'd0, bus.step_cnt_o}, 32'd0);
        bus.slow_clk_i = 1'b0;
        repeat (5) @(negedge clk);

        // Continuous run: three slow edges, three pulses.
        bus.run_i = 1'b1;
        repeat (4) @(negedge clk);
        check("run_state", {30'd0, bus.state_o}, 32'd1);
        for (int i = 0; i < 3; i++) slow_edge(1'b1);
        check("run_cnt", {28'd0, bus.step_cnt_o}, 32'd3);
        check("run_q_empty", exp_q.size(), 32'd0);

        // Step with a bouncing button.
        bus.run_i = 1'b0;
        repeat (4) @(negedge clk);
        check("stop_state", {30'd0, bus.state_o}, 32'd0);
        press_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            bus.step_ni = 1'b0;
            repeat (2) @(negedge clk);
            bus.step_ni = 1'b1;
            repeat (3) @(negedge clk);
        end
        check("bounce_state", {30'd0, bus.state_o}, 32'd0);
        bus.step_ni = 1'b0;
        repeat (10) @(negedge clk);
        bus.step_ni = 1'b1;
        repeat (8) @(negedge clk);
        check("press_count", press_cnt, 32'd1);
        check("step_state", {30'd0, bus.state_o}, 32'd2);
        slow_edge(1'b1);
        check("step_done_state", {30'd0, bus.state_o}, 32'd0);
        slow_edge(1'b0);
        check("step_q_empty", exp_q.size(), 32'd0);
        check("step_cnt", {28'd0, bus.step_cnt_o}, 32'd4);

        // Halt arriving together with a tick suppresses the pulse.
        bus.run_i = 1'b1;
        repeat (4) @(negedge clk);
        check("halt_pre_state", {30'd0, bus.state_o}, 32'd1);
        bus.slow_clk_i = 1'b1;
        repeat (2) @(negedge clk);
        bus.halt_i = 1'b1;
        repeat (3) @(negedge clk);
        bus.slow_clk_i = 1'b0;
        check("halt_state", {30'd0, bus.state_o}, 32'd3);
        repeat (3) @(negedge clk);
        bus.halt_i = 1'b0;
        @(negedge clk);
        check("unhalt_stop", {30'd0, bus.state_o}, 32'd0);
        @(negedge clk);
        check("unhalt_run", {30'd0, bus.state_o}, 32'd1);
        repeat (3) @(negedge clk);
        slow_edge(1'b1);
        check("halt_cnt", {28'd0, bus.step_cnt_o}, 32'd5);

        // Counter wrap: 17 pulses from zero leave 1.
        do_reset();
        repeat (2) @(negedge clk);
        bus.run_i = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 17; i++) slow_edge(1'b1);
        check("wrap_cnt", {28'd0, bus.step_cnt_o}, 32'd1);
        check("wrap_q_empty", exp_q.size(), 32'd0);

        // Reset while a step is pending.
        bus.run_i = 1'b0;
        repeat (4) @(negedge clk);
        bus.step_ni = 1'b0;
        repeat (9) @(negedge clk);
        check("pend_state", {30'd0, bus.state_o}, 32'd2);
        bus.step_ni = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_state", {30'd0, bus.state_o}, 32'd0);
        check("midrst_cnt", {28'd0, bus.step_cnt_o}, 32'd0);
        check("midrst_en", {31'd0, bus.cpu_en_o}, 32'd0);
        exp_q.delete();
        exp_cnt = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        slow_edge(1'b0);
        slow_edge(1'b0);
        check("post_rst_state", {30'd0, bus.state_o}, 32'd0);
        check("post_rst_cnt", {28'd0, bus.step_cnt_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
